// File: rtl/serializzatore_if.sv
// Handshake and serial-line bundle between a 4-bit producer and the serializzatore.
interface serializzatore_if;
    logic [3:0] dato_in;
    logic       valid_in;
    logic       ready_out;
    logic       tx;
    logic       busy;
    logic [7:0] frame_cnt;

    modport master (
        output dato_in,
        output valid_in,
        input  ready_out,
        input  tx,
        input  busy,
        input  frame_cnt
    );

    modport slave (
        input  dato_in,
        input  valid_in,
        output ready_out,
        output tx,
        output busy,
        output frame_cnt
    );
endinterface

// File: rtl/serializzatore.sv
// Framed serial transmitter for a 4-bit value: start, 4 data bits LSB first, optional even
// parity (macro PARITY_EN), stop; each bit held BIT_TICKS cycles. Counts completed frames.
module serializzatore #(
    parameter int unsigned BIT_TICKS = 4
) (
    input  logic            clock,
    input  logic            reset,
    serializzatore_if.slave bus
);
    localparam logic [7:0] TICK_LAST = 8'(BIT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tick_q, tick_d;
    logic [1:0] bit_idx_q, bit_idx_d;
    logic [3:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       bit_done_s;
`ifdef PARITY_EN
    logic       par_q, par_d;
`endif

    assign bit_done_s = (tick_q == TICK_LAST);

    // Next-state logic: frame sequencing, bit timing and frame counting
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_cnt_d = frame_cnt_q;
`ifdef PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    state_d   = START;
                    tick_d    = 8'd0;
                    bit_idx_d = 2'd0;
                    shift_d   = bus.dato_in;
`ifdef PARITY_EN
                    par_d     = ^bus.dato_in;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_done_s) begin
                    state_d   = DATA;
                    tick_d    = 8'd0;
                    bit_idx_d = 2'd0;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    tick_d    = 8'd0;
                    shift_d   = {1'b0, shift_q[3:1]};
                    bit_idx_d = bit_idx_q + 2'd1;
                    if (bit_idx_q == 2'd3) begin
`ifdef PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bit_done_s) begin
                    state_d = STOP;
                    tick_d  = 8'd0;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
`endif
            STOP: begin
                if (bit_done_s) begin
                    state_d     = IDLE;
                    tick_d      = 8'd0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = 8'd0;
            end
        endcase
    end

    // Line level for the coming cycle, so tx is a plain flop output
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State registers with synchronous reset; reset aborts any frame in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_q      <= 8'd0;
            bit_idx_q   <= 2'd0;
            shift_q     <= 4'd0;
            tx_q        <= 1'b1;
            frame_cnt_q <= 8'd0;
`ifdef PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign bus.tx        = tx_q;
    assign bus.ready_out = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_serializzatore.sv
// Self-checking bench for serializzatore: table of frames checked through a tx scoreboard,
// plus hand sequences for back-to-back frames, mid-frame reset and frame counter wrap.
module tb_serializzatore;
    localparam int BT = 4;
`ifdef PARITY_EN
    localparam int NBITS = 7;
`else
    localparam int NBITS = 6;
`endif

    typedef struct {
        logic [3:0] dato;
        logic       par;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    logic exp_q[$];

    always #5 clock = ~clock;

    serializzatore_if bus4 ();
    serializzatore_if bus1 ();

    serializzatore #(.BIT_TICKS(BT)) dut4 (.clock(clock), .reset(reset), .bus(bus4));
    serializzatore #(.BIT_TICKS(1))  dut1 (.clock(clock), .reset(reset), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bits(input logic b);
        for (int t = 0; t < BT; t++) exp_q.push_back(b);
    endtask

    task automatic push_frame(input logic [3:0] v, input logic p);
        push_bits(1'b0);
        for (int k = 0; k < 4; k++) push_bits(v[k]);
`ifdef PARITY_EN
        push_bits(p);
`endif
        push_bits(1'b1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus4.ready_out !== 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input logic [3:0] v, input logic p, input int idx);
        int busy_cyc = 0;
        wait_ready();
        bus4.dato_in  = v;
        bus4.valid_in = 1'b1;
        push_frame(v, p);
        @(negedge clock);
        bus4.valid_in = 1'b0;
        bus4.dato_in  = ~v;
        while (bus4.busy === 1'b1 && busy_cyc < 200) begin
            busy_cyc++;
            @(negedge clock);
        end
        check("busy_cycles", busy_cyc, NBITS * BT);
        check("frame_cnt", bus4.frame_cnt, idx);
        check("ready_after", bus4.ready_out, 32'd1);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    // Scoreboard: every busy cycle of the BIT_TICKS=4 instance pops one expected tx level
    always @(negedge clock) begin
        if (mon_en && bus4.busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got busy with empty scoreboard, tx=%b", bus4.tx);
            end else begin
                check("tx_bit", bus4.tx, exp_q.pop_front());
            end
        end
    end

    initial begin
        vec_t vecs[7];
        logic exp1[$];
        int   n;

        vecs[0] = '{dato: 4'b1011, par: 1'b1};
        vecs[1] = '{dato: 4'b0111, par: 1'b1};
        vecs[2] = '{dato: 4'b0011, par: 1'b0};
        vecs[3] = '{dato: 4'b0000, par: 1'b0};
        vecs[4] = '{dato: 4'b1111, par: 1'b0};
        vecs[5] = '{dato: 4'b1000, par: 1'b1};
        vecs[6] = '{dato: 4'b0110, par: 1'b0};

        bus4.dato_in  = 4'd0;
        bus4.valid_in = 1'b0;
        bus1.dato_in  = 4'd0;
        bus1.valid_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_tx", bus4.tx, 32'd1);
        check("rst_ready", bus4.ready_out, 32'd1);
        check("rst_busy", bus4.busy, 32'd0);
        check("rst_frame_cnt", bus4.frame_cnt, 32'd0);
        repeat (3) @(negedge clock);
        check("idle_tx", bus4.tx, 32'd1);
        check("idle_busy", bus4.busy, 32'd0);
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].dato, vecs[i].par, i + 1);
        end

        // Back-to-back: valid held high, dato changed during the frame
        wait_ready();
        bus4.dato_in  = 4'b1011;
        bus4.valid_in = 1'b1;
        push_frame(4'b1011, 1'b1);
        @(negedge clock);
        bus4.dato_in = 4'b0000;
        n = 0;
        while (bus4.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
        check("b2b_busy_cycles", n, NBITS * BT);
        check("b2b_gap_ready", bus4.ready_out, 32'd1);
        check("b2b_gap_tx", bus4.tx, 32'd1);
        check("b2b_frame_cnt", bus4.frame_cnt, 32'd8);
        push_frame(4'b0000, 1'b0);
        @(negedge clock);
        check("b2b_second_busy", bus4.busy, 32'd1);
        repeat (3 * BT) @(negedge clock);

        // Reset in DATA bit 2; the idle BT=1 instance sees valid on the reset edge too
        mon_en = 1'b0;
        reset  = 1'b1;
        bus1.dato_in  = 4'b1011;
        bus1.valid_in = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus1.valid_in = 1'b0;
        bus4.valid_in = 1'b0;
        exp_q.delete();
        check("midrst_tx", bus4.tx, 32'd1);
        check("midrst_ready", bus4.ready_out, 32'd1);
        check("midrst_busy", bus4.busy, 32'd0);
        check("midrst_frame_cnt", bus4.frame_cnt, 32'd0);
        check("rst_wins_busy", bus1.busy, 32'd0);
        check("rst_wins_tx", bus1.tx, 32'd1);
        @(negedge clock);
        check("midrst_still_idle", bus4.busy, 32'd0);
        mon_en = 1'b1;

        // BIT_TICKS=1: 256 back-to-back frames, counter wrap
        exp1 = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef PARITY_EN
        exp1.push_back(1'b1);
`endif
        exp1.push_back(1'b1);
        bus1.dato_in  = 4'b1011;
        bus1.valid_in = 1'b1;
        for (int f = 1; f <= 256; f++) begin
            n = 0;
            while (bus1.busy !== 1'b1 && n < 20) begin
                n++;
                @(negedge clock);
            end
            if (f <= 3) check("bt1_idle_gap", n, 32'd1);
            n = 0;
            while (bus1.busy === 1'b1 && n < 20) begin
                if (f == 1 && n < NBITS) check("bt1_tx", bus1.tx, exp1[n]);
                n++;
                @(negedge clock);
            end
            if (f == 1) check("bt1_busy_cycles", n, NBITS);
            if (f == 1 || f == 255 || f == 256) check("bt1_frame_cnt", bus1.frame_cnt, f % 256);
        end
        bus1.valid_in = 1'b0;
        check("bt4_untouched", bus4.frame_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
